// File: rtl/bip_control_unit_pkg.sv
// Shared definitions for the BIP control unit: opcodes, FSM states,
// accumulator-input mux encodings, control word and default widths.
package bip_control_unit_pkg;

    localparam int PC_W_DEF  = 11;
    localparam int OPC_W_DEF = 5;
    localparam int OPR_W_DEF = 11;
    localparam int DB_DEF    = OPC_W_DEF + OPR_W_DEF;

    localparam logic [4:0] OPC_HLT  = 5'b00000;
    localparam logic [4:0] OPC_STO  = 5'b00001;
    localparam logic [4:0] OPC_LD   = 5'b00010;
    localparam logic [4:0] OPC_LDI  = 5'b00011;
    localparam logic [4:0] OPC_ADD  = 5'b00100;
    localparam logic [4:0] OPC_ADDI = 5'b00101;
    localparam logic [4:0] OPC_SUB  = 5'b00110;
    localparam logic [4:0] OPC_SUBI = 5'b00111;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_IMM = 2'd1;
    localparam logic [1:0] SEL_RAM = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    // rd_ram applies in DECODE, the remaining strobes in EXEC.
    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_acc;
        logic       rd_ram;
        logic       wr_ram;
        logic       halt;
    } ctrl_t;

    function automatic logic is_active(state_e s);
        return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXEC);
    endfunction

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode -> control word decode for the BIP control unit.
module bip_decoder
    import bip_control_unit_pkg::*;
#(
    parameter int OPC_W = OPC_W_DEF
) (
    input  logic [OPC_W-1:0] opcode_i,
    output ctrl_t            ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OPC_W'(OPC_HLT): ctrl_o.halt = 1'b1;
            OPC_W'(OPC_STO): ctrl_o.wr_ram = 1'b1;
            OPC_W'(OPC_LD): begin
                ctrl_o.rd_ram = 1'b1;
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SEL_RAM;
            end
            OPC_W'(OPC_LDI): begin
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SEL_IMM;
            end
            OPC_W'(OPC_ADD): begin
                ctrl_o.rd_ram = 1'b1;
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SEL_ALU;
            end
            OPC_W'(OPC_ADDI): begin
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SEL_ALU;
                ctrl_o.sel_b  = 1'b1;
            end
            OPC_W'(OPC_SUB): begin
                ctrl_o.rd_ram = 1'b1;
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SEL_ALU;
                ctrl_o.op     = 1'b1;
            end
            OPC_W'(OPC_SUBI): begin
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SEL_ALU;
                ctrl_o.sel_b  = 1'b1;
                ctrl_o.op     = 1'b1;
            end
            default: ctrl_o = '0;  // undefined opcodes execute as NOP
        endcase
    end

endmodule

// File: rtl/bip_control_unit.sv
// Multi-cycle BIP control unit: FSM, PC, IR and datapath control decode.
// Optional cycle counter output Ciclos enabled by defining BIP_CYCLE_COUNT_EN.
module bip_control_unit
    import bip_control_unit_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int OPC_W = OPC_W_DEF,
    parameter int OPR_W = OPR_W_DEF,
    parameter int DB    = OPC_W + OPR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              Start,
    input  logic [DB-1:0]     Instr,
    output logic [PC_W-1:0]   ProgAddr,
    output logic [OPR_W-1:0]  DataAddr,
    output logic [OPR_W-1:0]  Operand,
    output logic [1:0]        SelA,
    output logic              SelB,
    output logic              Op,
    output logic              WrAcc,
    output logic              RdRam,
    output logic              WrRam,
`ifdef BIP_CYCLE_COUNT_EN
    output logic              Halted,
    output logic [31:0]       Ciclos
`else
    output logic              Halted
`endif
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DB-1:0]     ir_q, ir_d;
    logic [OPC_W-1:0]  dec_opc;
    ctrl_t             ctrl;

    // In DECODE the fresh memory word is decoded; in EXEC the latched IR is.
    assign dec_opc = (state_q == ST_DECODE) ? Instr[DB-1 -: OPC_W]
                                            : ir_q[DB-1 -: OPC_W];

    bip_decoder #(
        .OPC_W (OPC_W)
    ) u_dec (
        .opcode_i (dec_opc),
        .ctrl_o   (ctrl)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE:   if (Start) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d    = Instr;
                state_d = ctrl.halt ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                pc_d    = pc_q + 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign ProgAddr = pc_q;

    // Strobes come from the state register, so reset kills them at once.
    always_comb begin
        DataAddr = '0;
        Operand  = '0;
        SelA     = SEL_ALU;
        SelB     = 1'b0;
        Op       = 1'b0;
        WrAcc    = 1'b0;
        RdRam    = 1'b0;
        WrRam    = 1'b0;
        Halted   = 1'b0;
        case (state_q)
            ST_DECODE: begin
                DataAddr = Instr[OPR_W-1:0];
                RdRam    = ctrl.rd_ram;
            end
            ST_EXEC: begin
                DataAddr = ir_q[OPR_W-1:0];
                Operand  = ir_q[OPR_W-1:0];
                SelA     = ctrl.sel_a;
                SelB     = ctrl.sel_b;
                Op       = ctrl.op;
                WrAcc    = ctrl.wr_acc;
                WrRam    = ctrl.wr_ram;
            end
            ST_HALT:   Halted = 1'b1;
            default:   ;
        endcase
    end

`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;

    assign cyc_d = is_active(state_q) ? cyc_q + 32'd1 : cyc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc_q <= '0;
        else          cyc_q <= cyc_d;
    end

    assign Ciclos = cyc_q;
`endif

endmodule
